// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side monitor for a two-digit multiplexed 7-segment
// bus. Synchronises the segment/digit-select lines, accepts only patterns that
// stay stable for STABLE_CYCLES samples, decodes them back to BCD and
// publishes a 0..99 value once per complete tens+ones frame.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] digit_seg,
    input  logic [1:0] digit_con,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [6:0] value,
    output logic       valid,
    output logic       frame_err,
    output logic       stale
);

    localparam logic [7:0]  STAB_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [23:0] TO_MAX    = 24'(TIMEOUT_CYCLES);

    // Segment lines a..g (dp already stripped) back to a BCD digit; 4'hF = undecodable.
    function automatic logic [3:0] seg_decode(input logic [6:0] seg);
        logic [3:0] code;
        case (seg)
            7'h7E:   code = 4'd0;
            7'h30:   code = 4'd1;
            7'h6D:   code = 4'd2;
            7'h79:   code = 4'd3;
            7'h33:   code = 4'd4;
            7'h5B:   code = 4'd5;
            7'h5F:   code = 4'd6;
            7'h70:   code = 4'd7;
            7'h7F:   code = 4'd8;
            7'h7B:   code = 4'd9;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    logic [9:0]  s1_r, s2_r, s3_r;
    logic [7:0]  stab_cnt_r;
    logic [23:0] to_cnt_r;
    logic [3:0]  tens_cap_r, ones_cap_r;
    logic        tens_seen_r, ones_seen_r;
    logic [3:0]  tens_r, ones_r;
    logic [6:0]  value_r;
    logic        valid_r, frame_err_r, stale_r;

    logic        match_s, accept_s, publish_s, pub_ok_s, timeout_hit_s;
    logic [1:0]  con_s;
    logic [3:0]  code_s, pub_tens_s, pub_ones_s;
    logic [6:0]  pub_value_s, tens7_s;
    logic [23:0] to_next_s;

    // Accept detection, frame completion and timeout next-state.
    always_comb begin
        match_s       = (s2_r == s3_r);
        accept_s      = match_s && (stab_cnt_r == STAB_LAST);
        con_s         = s2_r[9:8];
        code_s        = seg_decode(s2_r[7:1]);
        publish_s     = 1'b0;
        pub_tens_s    = tens_cap_r;
        pub_ones_s    = ones_cap_r;
        if (accept_s) begin
            if ((con_s == 2'b10) && ones_seen_r) begin
                publish_s  = 1'b1;
                pub_tens_s = code_s;
            end else if ((con_s == 2'b01) && tens_seen_r) begin
                publish_s  = 1'b1;
                pub_ones_s = code_s;
            end else begin
                publish_s  = 1'b0;
            end
        end else begin
            publish_s = 1'b0;
        end
        pub_ok_s    = (pub_tens_s <= 4'd9) && (pub_ones_s <= 4'd9);
        tens7_s     = {3'b000, pub_tens_s};
        pub_value_s = (tens7_s << 3) + (tens7_s << 1) + {3'b000, pub_ones_s};
        if (accept_s) begin
            to_next_s = 24'd0;
        end else if (to_cnt_r < TO_MAX) begin
            to_next_s = to_cnt_r + 24'd1;
        end else begin
            to_next_s = to_cnt_r;
        end
        timeout_hit_s = !accept_s && (to_next_s == TO_MAX);
    end

    // Two-flop synchroniser plus one-sample history for the stability compare.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            s1_r <= 10'd0;
            s2_r <= 10'd0;
            s3_r <= 10'd0;
        end else begin
            s1_r <= {digit_con, digit_seg};
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Run-length of identical samples, saturating so a run accepts only once.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            stab_cnt_r <= 8'd0;
        end else if (!match_s) begin
            stab_cnt_r <= 8'd0;
        end else if (stab_cnt_r < STAB_MAX) begin
            stab_cnt_r <= stab_cnt_r + 8'd1;
        end else begin
            stab_cnt_r <= stab_cnt_r;
        end
    end

    // Inactivity counter; any accepted sample (even a blank) counts as activity.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            to_cnt_r <= 24'd0;
            stale_r  <= 1'b0;
        end else begin
            to_cnt_r <= to_next_s;
            stale_r  <= (to_next_s == TO_MAX);
        end
    end

    // Per-digit capture and seen flags; publish or timeout discards the frame.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            tens_cap_r  <= 4'd0;
            ones_cap_r  <= 4'd0;
            tens_seen_r <= 1'b0;
            ones_seen_r <= 1'b0;
        end else if (publish_s) begin
            tens_seen_r <= 1'b0;
            ones_seen_r <= 1'b0;
        end else if (accept_s) begin
            if (con_s == 2'b10) begin
                tens_cap_r  <= code_s;
                tens_seen_r <= 1'b1;
            end else if (con_s == 2'b01) begin
                ones_cap_r  <= code_s;
                ones_seen_r <= 1'b1;
            end else begin
                tens_seen_r <= tens_seen_r;
            end
        end else if (timeout_hit_s) begin
            tens_seen_r <= 1'b0;
            ones_seen_r <= 1'b0;
        end else begin
            tens_seen_r <= tens_seen_r;
        end
    end

    // Published result and one-cycle status pulses.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            tens_r      <= 4'd0;
            ones_r      <= 4'd0;
            value_r     <= 7'd0;
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            valid_r     <= publish_s && pub_ok_s;
            frame_err_r <= publish_s && !pub_ok_s;
            if (publish_s && pub_ok_s) begin
                tens_r  <= pub_tens_s;
                ones_r  <= pub_ones_s;
                value_r <= pub_value_s;
            end else begin
                value_r <= value_r;
            end
        end
    end

    assign tens      = tens_r;
    assign ones      = ones_r;
    assign value     = value_r;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
    assign stale     = stale_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed plus randomised stimulus against a run-length
// and frame-level reference model of the segment scan decoder.
module tb_seg_scan_decoder;

    localparam int S = 4;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic [7:0] digit_seg = 8'd0;
    logic [1:0] digit_con = 2'd0;
    logic [3:0] tens, ones;
    logic [6:0] value;
    logic       valid, frame_err, stale;

    seg_scan_decoder #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .res(res), .digit_seg(digit_seg), .digit_con(digit_con),
        .tens(tens), .ones(ones), .value(value), .valid(valid),
        .frame_err(frame_err), .stale(stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [9:0] hist[$];
    int         rl[$];
    int         idle;
    logic       tseen, oseen;
    logic [3:0] tcap, ocap;
    logic [3:0] m_tens, m_ones;
    logic [6:0] m_value;
    logic       m_valid, m_err, m_stale;

    logic [7:0] pat [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                             8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] digit_of(input logic [7:0] s);
        logic [7:0] p;
        for (int i = 0; i < 10; i++) begin
            p = pat[i];
            if (s[7:1] == p[7:1]) return 4'(i);
        end
        return 4'hF;
    endfunction

    task automatic model_reset();
        hist.delete(); rl.delete();
        hist.push_back(10'd0); rl.push_back(1);
        hist.push_back(10'd0); rl.push_back(2);
        hist.push_back(10'd0); rl.push_back(3);
        idle = 0; tseen = 1'b0; oseen = 1'b0; tcap = 4'd0; ocap = 4'd0;
        m_tens = 4'd0; m_ones = 4'd0; m_value = 7'd0;
        m_valid = 1'b0; m_err = 1'b0; m_stale = 1'b0;
    endtask

    task automatic model_publish(input logic [3:0] t, input logic [3:0] o);
        if (t <= 4'd9 && o <= 4'd9) begin
            m_tens = t; m_ones = o; m_value = 7'(int'(t) * 10 + int'(o));
            m_valid = 1'b1;
        end else begin
            m_err = 1'b1;
        end
        tseen = 1'b0; oseen = 1'b0;
    endtask

    // One clock edge: a pattern is accepted two edges after its sampled run reaches S+1.
    task automatic model_edge(input logic [9:0] x);
        logic [9:0] v;
        logic [3:0] code;
        rl.push_back((x == hist[$]) ? rl[$] + 1 : 1);
        hist.push_back(x);
        void'(hist.pop_front()); void'(rl.pop_front());
        m_valid = 1'b0; m_err = 1'b0;
        if (rl[0] == S + 1) begin
            v = hist[0];
            code = digit_of(v[7:0]);
            idle = 0;
            if (v[9:8] == 2'b10) begin
                if (oseen) model_publish(code, ocap);
                else begin tcap = code; tseen = 1'b1; end
            end else if (v[9:8] == 2'b01) begin
                if (tseen) model_publish(tcap, code);
                else begin ocap = code; oseen = 1'b1; end
            end
        end else begin
            if (idle < T) idle++;
            if (idle == T) begin tseen = 1'b0; oseen = 1'b0; end
        end
        m_stale = (idle == T);
    endtask

    task automatic compare_all();
        check_eq("valid", valid, m_valid);
        check_eq("frame_err", frame_err, m_err);
        check_eq("stale", stale, m_stale);
        check_eq("tens", tens, m_tens);
        check_eq("ones", ones, m_ones);
        check_eq("value", value, m_value);
    endtask

    // Called at a negedge; drives, lets one posedge pass, checks, returns at next negedge.
    task automatic cycle(input logic [1:0] c, input logic [7:0] s);
        digit_con = c; digit_seg = s;
        @(posedge clk);
        model_edge({c, s});
        #1 compare_all();
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] c, input logic [7:0] s, input int n);
        repeat (n) cycle(c, s);
    endtask

    task automatic do_reset(input int n);
        res = 1'b1;
        repeat (n) begin
            digit_con = 2'($urandom); digit_seg = 8'($urandom);
            @(posedge clk);
            #1;
            check_eq("rst_out", {tens, ones, value, valid, frame_err, stale}, 21'd0);
            @(negedge clk);
        end
        res = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s;
        logic [1:0] c;
        @(negedge clk);
        do_reset(3);

        // Idle blank bus after reset: no publish, stale eventually.
        hold(2'b00, 8'h00, 70);

        // Nominal frame 2/3.
        hold(2'b10, 8'hDA, 8);
        for (int i = 0; i < 8; i++) begin
            cycle(2'b01, 8'hF2);
            check_eq("nom_valid", valid, (i == 6));
        end
        check_eq("nom_value", value, 7'd23);

        // Glitch rejection during a stable 7, then 9 -> 79.
        hold(2'b10, 8'hE0, 8);
        hold(2'b10, 8'hFE, 2);
        hold(2'b10, 8'hE0, 8);
        hold(2'b01, 8'hF6, 8);
        check_eq("glitch_value", value, 7'd79);

        // dp ignored, ones before tens -> 95.
        hold(2'b01, 8'hB7, 8);
        hold(2'b10, 8'hF7, 8);
        check_eq("dp_value", value, 7'd95);

        // Undecodable tens -> frame_err, value holds; then 0/0.
        hold(2'b10, 8'h02, 8);
        hold(2'b01, 8'h60, 8);
        check_eq("bad_value", value, 7'd95);
        hold(2'b10, 8'hFC, 8);
        hold(2'b01, 8'hFC, 8);
        check_eq("zero_value", value, 7'd0);

        // Timeout: tens=1 accepted at call 6, stale 64 edges later, partial frame dropped.
        for (int i = 0; i < 72; i++) begin
            cycle(2'b10, 8'h60);
            check_eq("stale_timing", stale, (i >= 70));
        end
        hold(2'b01, 8'h66, 8);
        check_eq("stale_drop", stale, 1'b0);
        check_eq("to_discard", value, 7'd0);
        hold(2'b10, 8'hFE, 8);
        check_eq("to_value", value, 7'd84);

        // Reset mid-frame loses the captured tens.
        hold(2'b10, 8'hB6, 8);
        do_reset(3);
        hold(2'b01, 8'hF6, 8);
        check_eq("rst_mid_valid", value, 7'd0);

        // Randomised patterns and hold lengths.
        repeat (250) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: c = 2'b10;
                4, 5, 6, 7: c = 2'b01;
                8:          c = 2'b00;
                default:    c = 2'b11;
            endcase
            if ($urandom_range(0, 9) < 8) s = pat[$urandom_range(0, 9)] | 8'($urandom_range(0, 1));
            else s = 8'($urandom);
            hold(c, s, ($urandom_range(0, 19) == 0) ? 70 : $urandom_range(1, 8));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
